// File: rtl/axi_debounce_regs.sv
// AXI4-Lite register block around a per-button synchronizer and debounce counter.
// Exposes CTRL, THRESH, STATUS and W1C EVENT; irq is a registered level.
module axi_debounce_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_BUTTONS        = 4,
    parameter int CNT_WIDTH          = 20,
    parameter int DEFAULT_THRESH     = 1000000
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    input  logic [NUM_BUTTONS-1:0]        btn_in,
    output logic                          irq
);

    logic                   alive_q;
    logic                   accept_q;
    logic                   bvalid_q, bvalid_d;
    logic                   rvalid_q, rvalid_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [1:0]             ctrl_q, ctrl_d;
    logic [CNT_WIDTH-1:0]   thresh_q, thresh_d;
    logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
    logic [NUM_BUTTONS-1:0] deb_q, deb_d;
    logic [NUM_BUTTONS-1:0] event_q, event_d;
    logic [CNT_WIDTH-1:0]   cnt_q [NUM_BUTTONS];
    logic [CNT_WIDTH-1:0]   cnt_d [NUM_BUTTONS];
    logic                   irq_q, irq_d;

    logic                   wr_acc, rd_acc;
    logic [31:0]            wmask, wdata_m;
    logic [NUM_BUTTONS-1:0] clr;
    logic [NUM_BUTTONS-1:0] rise;
    logic [CNT_WIDTH-1:0]   thr_m1;
    logic [31:0]            ctrl_ext, thresh_ext, status_ext, event_ext;
    logic                   unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                         wdata_m, wmask};

    always_comb begin
        // alive_q keeps READY low during reset and the first cycle after it
        wr_acc = alive_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~accept_q;
        rd_acc = alive_q & S_AXI_ARVALID & ~rvalid_q;

        for (int b = 0; b < 4; b++) begin
            wmask[8*b +: 8] = {8{S_AXI_WSTRB[b]}};
        end
        wdata_m = S_AXI_WDATA & wmask;

        ctrl_ext   = '0;
        thresh_ext = '0;
        status_ext = '0;
        event_ext  = '0;
        ctrl_ext[1:0]               = ctrl_q;
        thresh_ext[CNT_WIDTH-1:0]   = thresh_q;
        status_ext[NUM_BUTTONS-1:0] = deb_q;
        event_ext[NUM_BUTTONS-1:0]  = event_q;

        rdata_d = rdata_q;
        if (rd_acc) begin
            case (S_AXI_ARADDR[3:2])
                2'd0:    rdata_d = ctrl_ext;
                2'd1:    rdata_d = thresh_ext;
                2'd2:    rdata_d = status_ext;
                default: rdata_d = event_ext;
            endcase
        end
        rvalid_d = rd_acc | (rvalid_q & ~S_AXI_RREADY);
        bvalid_d = wr_acc | (bvalid_q & ~S_AXI_BREADY);

        ctrl_d   = ctrl_q;
        thresh_d = thresh_q;
        clr      = '0;
        if (wr_acc) begin
            case (S_AXI_AWADDR[3:2])
                2'd0:    ctrl_d   = (ctrl_q & ~wmask[1:0]) | wdata_m[1:0];
                2'd1:    thresh_d = (thresh_q & ~wmask[CNT_WIDTH-1:0]) | wdata_m[CNT_WIDTH-1:0];
                2'd3:    clr      = wdata_m[NUM_BUTTONS-1:0];
                default: ;
            endcase
        end

        // a stored threshold of 0 behaves like 1
        thr_m1 = (thresh_q == '0) ? '0 : thresh_q - CNT_WIDTH'(1);
        deb_d  = deb_q;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            cnt_d[i] = '0;
            if (ctrl_q[0] && (sync2_q[i] != deb_q[i])) begin
                if (cnt_q[i] >= thr_m1) begin
                    deb_d[i] = sync2_q[i];
                end else if (cnt_q[i] != '1) begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end

        // set wins over a coincident W1C clear
        rise    = deb_d & ~deb_q;
        event_d = (event_q & ~clr) | rise;
        irq_d   = ctrl_d[1] & (|event_d);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            alive_q  <= 1'b0;
            accept_q <= 1'b0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            ctrl_q   <= '0;
            thresh_q <= CNT_WIDTH'(DEFAULT_THRESH);
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            event_q  <= '0;
            irq_q    <= 1'b0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            alive_q  <= 1'b1;
            accept_q <= wr_acc;
            bvalid_q <= bvalid_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            ctrl_q   <= ctrl_d;
            thresh_q <= thresh_d;
            sync1_q  <= btn_in;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            event_q  <= event_d;
            irq_q    <= irq_d;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign S_AXI_AWREADY = wr_acc;
    assign S_AXI_WREADY  = wr_acc;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = rd_acc;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_axi_debounce_regs.sv
// Directed bench for axi_debounce_regs with a cycle-level behavioural model.
module tb_axi_debounce_regs;
    localparam int NB = 4;
    localparam int CW = 20;
    localparam int LIM = 60;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [NB-1:0] btn = '0;

    int checks = 0;
    int failures = 0;
    logic t1_irq;

    always #5 clk = ~clk;

    axi_debounce_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_BUTTONS(NB),
                        .CNT_WIDTH(CW), .DEFAULT_THRESH(1000000)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .btn_in(btn), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Behavioural model: a button's debounced level follows its synchronized
    // value once that value has differed for THRESH consecutive enabled cycles.
    logic [1:0]    m_ctrl;
    logic [CW-1:0] m_thr;
    logic [NB-1:0] m_deb, m_evt, h1, h2;
    int            m_run [NB];
    logic          m_irq;
    logic [31:0]   m_rexp;

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        case (a)
            2'd0:    return {30'b0, m_ctrl};
            2'd1:    return {{(32-CW){1'b0}}, m_thr};
            2'd2:    return {{(32-NB){1'b0}}, m_deb};
            default: return {{(32-NB){1'b0}}, m_evt};
        endcase
    endfunction

    initial begin
        m_rexp = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ctrl = '0; m_thr = CW'(1000000); m_deb = '0; m_evt = '0;
                h1 = '0; h2 = '0; m_irq = 1'b0;
                for (int i = 0; i < NB; i++) m_run[i] = 0;
            end else begin
                logic [31:0] mask;
                logic [1:0]  nctrl;
                logic [CW-1:0] nthr;
                logic [NB-1:0] clr, rise;
                int te;
                if (arvalid && arready) m_rexp = m_reg(araddr[3:2]);
                nctrl = m_ctrl; nthr = m_thr; clr = '0; rise = '0;
                for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{wstrb[b]}};
                if (awvalid && awready && wvalid && wready) begin
                    case (awaddr[3:2])
                        2'd0: nctrl = 2'((m_reg(2'd0) & ~mask) | (wdata & mask));
                        2'd1: nthr  = CW'((m_reg(2'd1) & ~mask) | (wdata & mask));
                        2'd3: clr   = NB'(wdata & mask);
                        default: ;
                    endcase
                end
                te = (m_thr == 0) ? 1 : int'(m_thr);
                for (int i = 0; i < NB; i++) begin
                    if (m_ctrl[0] && (h2[i] != m_deb[i])) begin
                        m_run[i]++;
                        if (m_run[i] >= te) begin
                            m_deb[i] = h2[i];
                            m_run[i] = 0;
                            rise[i]  = h2[i];
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
                h2 = h1; h1 = btn;
                m_ctrl = nctrl; m_thr = nthr;
                m_evt = (m_evt & ~clr) | rise;
                m_irq = m_ctrl[1] && (m_evt != '0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("irq_model", {31'b0, irq}, {31'b0, m_irq});
                if (bvalid) check("bresp", {30'b0, bresp}, 32'h0);
                if (rvalid) check("rresp", {30'b0, rresp}, 32'h0);
            end
        end
    end

    task automatic bound(input string name, input int n);
        checks++;
        if (n >= LIM) begin
            failures++;
            $display("FAIL %s actual=timeout required=handshake", name);
        end
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        #1;
        while (!(awready && wready) && n < LIM) begin @(negedge clk); #1; n++; end
        bound("aw_wait", n);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        t1_irq = irq;
        n = 0;
        while (!bvalid && n < LIM) begin @(negedge clk); n++; end
        bound("b_wait", n);
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n = 0;
        araddr = a; arvalid = 1; rready = 1;
        #1;
        while (!arready && n < LIM) begin @(negedge clk); #1; n++; end
        bound("ar_wait", n);
        @(negedge clk);
        arvalid = 0;
        n = 0;
        while (!rvalid && n < LIM) begin @(negedge clk); n++; end
        bound("r_wait", n);
        d = rdata;
        check("rdata_model", rdata, m_rexp);
        @(negedge clk);
    endtask

    task automatic read_expect(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(a, d);
        check(name, d, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int k;
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);

        read_expect("rst_ctrl",   4'h0, 32'h0);
        read_expect("rst_thresh", 4'h4, 32'h000F4240);
        read_expect("rst_status", 4'h8, 32'h0);
        read_expect("rst_event",  4'hC, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);

        axi_write(4'h4, 32'h10, 4'hF);
        read_expect("thresh_rw", 4'h4, 32'h10);
        axi_write(4'h4, 32'hFFFF_FFFF, 4'b0001);
        read_expect("thresh_strb", 4'h4, 32'hFF);
        axi_write(4'h8, 32'h5, 4'hF);
        read_expect("status_ro", 4'h8, 32'h0);

        axi_write(4'h4, 32'd16, 4'hF);
        axi_write(4'h0, 32'h1, 4'hF);
        btn[0] = 1'b1;
        repeat (10) @(negedge clk);
        btn[0] = 1'b0;
        repeat (30) @(negedge clk);
        read_expect("glitch_status", 4'h8, 32'h0);

        btn[0] = 1'b1;
        repeat (40) @(negedge clk);
        read_expect("hold_status", 4'h8, 32'h1);
        read_expect("hold_event",  4'hC, 32'h1);
        check("irq_masked", {31'b0, irq}, 32'h0);

        axi_write(4'h0, 32'h3, 4'hF);
        check("irq_enable_t1", {31'b0, t1_irq}, 32'h1);
        axi_write(4'hC, 32'h1, 4'hF);
        check("irq_clear_t1", {31'b0, t1_irq}, 32'h0);
        read_expect("event_cleared", 4'hC, 32'h0);

        btn[1] = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!irq && k < 100);
        check("latency_cycles", k, 18);
        read_expect("status_two", 4'h8, 32'h3);
        read_expect("event_two",  4'hC, 32'h2);
        axi_write(4'hC, 32'h2, 4'hF);

        axi_write(4'h4, 32'h1, 4'hF);
        btn[0] = 1'b0;
        repeat (10) @(negedge clk);
        read_expect("status_low0", 4'h8, 32'h2);
        btn[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        axi_write(4'hC, 32'h1, 4'hF);
        read_expect("set_wins", 4'hC, 32'h1);

        awaddr = 4'h0; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("aw_alone_ready", {31'b0, awready | wready}, 32'h0);
            @(negedge clk);
        end
        wvalid = 1; bready = 0;
        #1;
        check("aw_w_ready", {31'b0, awready & wready}, 32'h1);
        @(negedge clk);
        awaddr = 4'h4; wdata = 32'h20;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("bvalid_hold", {31'b0, bvalid}, 32'h1);
            check("second_stall", {31'b0, awready}, 32'h0);
            @(negedge clk);
        end
        bready = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        axi_write(4'h4, 32'h20, 4'hF);
        read_expect("first_write", 4'h0, 32'h1);
        read_expect("second_write", 4'h4, 32'h20);

        araddr = 4'h4; arvalid = 1; rready = 0;
        k = 0;
        #1;
        while (!arready && k < LIM) begin @(negedge clk); #1; k++; end
        bound("ar_hold_wait", k);
        @(negedge clk);
        arvalid = 0;
        v = rdata;
        for (int i = 0; i < 6; i++) begin
            check("rvalid_hold", {31'b0, rvalid}, 32'h1);
            check("rdata_stable", rdata, 32'h20);
            @(negedge clk);
        end
        check("rdata_held_same", rdata, v);
        rready = 1;
        @(negedge clk);

        axi_write(4'h0, 32'h3, 4'hF);
        check("irq_before_reset", {31'b0, irq}, 32'h1);
        araddr = 4'h0; arvalid = 1; rready = 0;
        k = 0;
        #1;
        while (!arready && k < LIM) begin @(negedge clk); #1; k++; end
        bound("ar_reset_wait", k);
        @(negedge clk);
        arvalid = 0;
        check("rvalid_pre_reset", {31'b0, rvalid}, 32'h1);
        #2 rst_n = 0;
        #1;
        check("rvalid_in_reset", {31'b0, rvalid}, 32'h0);
        check("irq_in_reset", {31'b0, irq}, 32'h0);
        check("arready_in_reset", {31'b0, arready}, 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        rready = 1;
        repeat (2) @(negedge clk);
        read_expect("ctrl_after_reset", 4'h0, 32'h0);
        read_expect("thresh_after_reset", 4'h4, 32'h000F4240);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
